// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_state_e    : fetch FSM states (FETCH / WAIT / DROP)
//   fetch_entry_t    : one decode-side FIFO entry {pc, instr}
//   DEFAULT_RESET_PC : default first fetch address after reset
//   FIFO_DEPTH       : number of entries in the fetch FIFO
//   next_pc()        : sequential PC increment (wraps modulo 2^32)
// Optional feature (see fetch_unit): FETCH_PERF_CNT_EN.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          FIFO_DEPTH       = 2;
  localparam int          FIFO_CNT_W       = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // may issue a request this cycle
    ST_WAIT  = 2'd1,  // request outstanding, data will be kept
    ST_DROP  = 2'd2   // request outstanding, data will be discarded
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO of fetched {pc, instr} entries between the fetch FSM
// and decode.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data (accepted when not full, or full with pop)
//   push_data   : entry to write
//   pop         : remove head entry (ignored when empty)
//   flush       : discard every entry; wins over push and pop
//   full, empty : occupancy flags
//   head        : oldest entry (all zeros after reset)
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  fetch_entry_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [FIFO_CNT_W-1:0]   count;
  logic                    do_push;
  logic                    do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + FIFO_CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count <= count - FIFO_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch: PC register, single-outstanding instruction-memory
// request FSM (FETCH / WAIT / DROP) and a 2-entry {pc, instr} FIFO to decode.
//
// Handshakes:
//   imem: imem_req is held with a stable imem_addr from issue until the cycle
//         imem_ack=1; imem_rdata is valid in that ack cycle. At most one
//         request is outstanding.
//   decode: the head entry transfers on a rising edge where
//         if_valid & id_ready; if_pc/if_instr are meaningful while if_valid=1.
//   Branch=1 redirects fetch to BrPC on that edge, flushes the FIFO and wins
//   over any push or pop in the same cycle.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   Branch, BrPC          : redirect request and target
//   imem_req, imem_addr   : instruction-memory request and address
//   imem_ack, imem_rdata  : completion and read data
//   if_valid, if_pc,
//   if_instr, id_ready    : decode-side entry and acceptance
//   fsm_state             : current FSM state (fetch_state_e encoding)
//   redirect_cnt          : cycles with Branch=1 (only with FETCH_PERF_CNT_EN)
//
// Build option: define FETCH_PERF_CNT_EN to add the redirect_cnt counter.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Branch,
  input  logic [31:0] BrPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready,
  output logic [1:0]  fsm_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] redirect_cnt
`endif
);

  fetch_state_e state;
  fetch_state_e state_nx;
  logic [31:0]  pc;
  logic [31:0]  pc_nx;
  logic [31:0]  addr_q;     // address of the outstanding request
  logic [31:0]  addr_nx;
  logic [31:0]  addr_out;
  logic         req_raw;
  logic         push;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t push_data;
  fetch_entry_t head;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    addr_nx  = addr_q;
    addr_out = addr_q;
    req_raw  = 1'b0;
    push     = 1'b0;
    case (state)
      ST_FETCH: begin
        if (Branch) begin
          pc_nx = BrPC;
        end else if (!fifo_full) begin
          // Issue only with a free slot, so the response always fits.
          req_raw  = 1'b1;
          addr_out = pc;
          addr_nx  = pc;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        req_raw = 1'b1;
        if (Branch) begin
          pc_nx    = BrPC;
          state_nx = imem_ack ? ST_FETCH : ST_DROP;
        end else if (imem_ack) begin
          push     = 1'b1;
          pc_nx    = next_pc(pc);
          state_nx = ST_FETCH;
        end
      end
      ST_DROP: begin
        // The returning data belongs to a redirected-away path; only the
        // newest redirect target matters.
        req_raw = 1'b1;
        if (Branch) begin
          pc_nx = BrPC;
        end
        if (imem_ack) begin
          state_nx = ST_FETCH;
        end
      end
      default: begin
        state_nx = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_FETCH;
      pc     <= RESET_PC;
      addr_q <= '0;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      addr_q <= addr_nx;
    end
  end

  // Reset gates the request combinationally so it drops the moment rst_n falls
  // and the first request appears as soon as rst_n rises.
  assign imem_req  = rst_n & req_raw;
  assign imem_addr = imem_req ? addr_out : '0;
  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // Decode-side FIFO
  // ---------------------------------------------------------------------------
  assign push_data.pc    = addr_q;
  assign push_data.instr = imem_rdata;
  assign pop             = if_valid & id_ready & ~Branch;

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (Branch),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign if_valid = ~fifo_empty;
  assign if_pc    = head.pc;
  assign if_instr = head.instr;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= '0;
    end else if (Branch) begin
      redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Inputs change on the falling edge; outputs
// are sampled 2 time units later, well away from the rising edge.
// The stimulus process pushes the expected issued addresses and accepted
// decode entries into queues; the monitor pops and compares them whenever the
// DUT issues a request or hands an entry to decode.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        Branch;
  logic [31:0] BrPC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;
  logic [1:0]  fsm_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redirect_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_ent_q[$];
  logic        pending = 1'b0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Branch     (Branch),
    .BrPC       (BrPC),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .id_ready   (id_ready),
    .fsm_state  (fsm_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .redirect_cnt (redirect_cnt)
`endif
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, applied on the falling edge. The memory model
  // answers with data derived from whatever address is being requested.
  task automatic cycle(input logic rst, input logic br, input logic [31:0] brpc,
                       input logic ack, input logic rdy);
    @(negedge clk);
    rst_n    = rst;
    Branch   = br;
    BrPC     = brpc;
    imem_ack = ack;
    id_ready = rdy;
    #1;
    imem_rdata = instr_of(imem_addr);
  endtask

  task automatic exp_addr(input logic [31:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic exp_ent(input logic [31:0] a);
    exp_ent_q.push_back({a, instr_of(a)});
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      pending = 1'b0;
    end else begin
      if (imem_req) begin
        if (!pending) begin
          if (exp_addr_q.size() == 0) begin
            check32("unexpected_issue", imem_addr, 32'hFFFF_FFFF);
          end else begin
            check32("issue_addr", imem_addr, exp_addr_q.pop_front());
          end
          pending = 1'b1;
        end else if (imem_ack) begin
          pending = 1'b0;
        end
      end
      if (if_valid && id_ready && !Branch) begin
        if (exp_ent_q.size() == 0) begin
          check32("unexpected_accept", if_pc, 32'hFFFF_FFFF);
        end else begin
          logic [63:0] e;
          e = exp_ent_q.pop_front();
          check32("accept_pc", if_pc, e[63:32]);
          check32("accept_instr", if_instr, e[31:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n      = 1'b0;
    Branch     = 1'b0;
    BrPC       = '0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    id_ready   = 1'b0;

    // Reset state
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check32("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check32("rst_imem_addr", imem_addr, 32'd0);
    check32("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check32("rst_if_pc", if_pc, 32'd0);
    check32("rst_if_instr", if_instr, 32'd0);

    // Sequential fetch with ack every cycle and decode always ready
    exp_addr(32'h0); exp_addr(32'h4); exp_addr(32'h8);
    exp_ent(32'h0);  exp_ent(32'h4);  exp_ent(32'h8);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);           // C1
    #1;
    check32("first_req", {31'b0, imem_req}, 32'd1);
    check32("first_addr", imem_addr, 32'h0);
    for (int i = 2; i <= 6; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);         // C2..C6
    end

    // Decode stalled: FIFO fills, requests stop, resume after one pop
    exp_addr(32'hC); exp_addr(32'h10);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);           // C7 issue 0xC
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);           // C8 push 0xC -> full
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);           // C9
    #1;
    check32("full_no_req_a", {31'b0, imem_req}, 32'd0);
    check32("full_head_pc", if_pc, 32'h8);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);           // C10
    #1;
    check32("full_no_req_b", {31'b0, imem_req}, 32'd0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);           // C11 pop 0x8
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);           // C12 resume
    #1;
    check32("resume_req", {31'b0, imem_req}, 32'd1);
    check32("resume_addr", imem_addr, 32'h10);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);           // C13 push 0x10

    // Redirect with nothing outstanding: flush and one-cycle latency
    exp_addr(32'h100);
    cycle(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);         // C14
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);           // C15
    #1;
    check32("redir_addr", imem_addr, 32'h100);
    check32("redir_flush", {31'b0, if_valid}, 32'd0);

    // Redirect while waiting, ack two cycles later is dropped
    exp_addr(32'h200); exp_ent(32'h200); exp_addr(32'h204);
    cycle(1'b1, 1'b1, 32'h200, 1'b0, 1'b0);         // C16 -> DROP
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);           // C17
    #1;
    check32("drop_addr_held", imem_addr, 32'h100);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);           // C18 ack discarded
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);           // C19
    #1;
    check32("after_drop_addr", imem_addr, 32'h200);
    check32("after_drop_empty", {31'b0, if_valid}, 32'd0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);           // C20 push 0x200
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);           // C21 issue 0x204

    // Redirect in the same cycle as ack
    exp_addr(32'h300); exp_ent(32'h300); exp_addr(32'h304);
    cycle(1'b1, 1'b1, 32'h300, 1'b1, 1'b1);         // C22
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);           // C23
    #1;
    check32("br_ack_addr", imem_addr, 32'h300);
    check32("br_ack_empty", {31'b0, if_valid}, 32'd0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);           // C24 push 0x300
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);           // C25 issue 0x304

    // Repeated redirect in DROP keeps the newest target
    exp_addr(32'h500);
    cycle(1'b1, 1'b1, 32'h400, 1'b0, 1'b1);         // C26 -> DROP
    cycle(1'b1, 1'b1, 32'h500, 1'b0, 1'b1);         // C27
    #1;
    check32("drop2_addr_held", imem_addr, 32'h304);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);           // C28 ack discarded
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);           // C29
    #1;
    check32("newest_target", imem_addr, 32'h500);
    cycle(1'b1, 1'b1, 32'h600, 1'b0, 1'b1);         // C30 -> DROP
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);           // C31
    #1;
`ifdef FETCH_PERF_CNT_EN
    check32("redirect_cnt", redirect_cnt, 32'd6);
`endif

    // Asynchronous reset while in DROP
    #1;
    rst_n = 1'b0;
    #1;
    check32("async_rst_req", {31'b0, imem_req}, 32'd0);
    check32("async_rst_addr", imem_addr, 32'd0);
    check32("async_rst_valid", {31'b0, if_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check32("async_rst_cnt", redirect_cnt, 32'd0);
`endif
    exp_addr(32'h0); exp_ent(32'h0); exp_addr(32'h4);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);           // C32 held in reset
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);           // C33 restart
    #1;
    check32("restart_addr", imem_addr, 32'h0);
    check32("restart_req", {31'b0, imem_req}, 32'd1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);           // C34 push 0x0
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);           // C35 issue 0x4
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);           // C36
    #3;

    check32("addr_q_drained", exp_addr_q.size(), 32'd0);
    check32("ent_q_drained", exp_ent_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port Branch, input, 1, redirect request from the branch-calculation stage.
REQ-005 SHALL have port BrPC, input, 32, redirect target, sampled when Branch=1.
REQ-006 SHALL have ports imem_req (output, 1), imem_addr (output, 32), imem_ack (input, 1) and imem_rdata (input, 32), the instruction-memory request, address, completion and read data; data is valid in the ack cycle.
REQ-007 SHALL have ports if_valid (output, 1), if_pc (output, 32) and if_instr (output, 32), the decode-side entry valid flag, its fetch address and its instruction word.
REQ-008 SHALL have port id_ready, input, 1, decode accepts the head entry when if_valid & id_ready.

Function
REQ-009 SHALL keep a fetch PC register and a 2-entry FIFO of {pc, instr}.
REQ-010 SHALL implement states FETCH, WAIT and DROP.
REQ-011 In FETCH, SHALL assert imem_req with imem_addr=PC when FIFO count<2 and Branch=0, then go to WAIT.
REQ-012 In WAIT, SHALL hold imem_req=1 and imem_addr stable until imem_ack.
REQ-013 On ack in WAIT, SHALL push {PC, imem_rdata}, set PC=PC+4 modulo 2^32, and return to FETCH.
REQ-014 SHALL keep at most one request outstanding.
REQ-015 On Branch=1, SHALL flush the FIFO and load PC=BrPC on that edge.
REQ-016 A redirect in WAIT without ack SHALL move to DROP.
REQ-017 In DROP, SHALL keep imem_req=1 until ack, discard the returned data, then go to FETCH.
REQ-018 Branch=1 in DROP SHALL overwrite PC with the newest BrPC and remain in DROP.
REQ-019 Branch=1 together with imem_ack SHALL discard the data and go to FETCH with PC=BrPC.
REQ-020 Redirect latency SHALL be one cycle: Branch at cycle N gives imem_addr=BrPC at N+1 when nothing is outstanding.
REQ-021 Simultaneous pop and push SHALL keep count unchanged, and a push to an empty FIFO SHALL appear on if_valid the next cycle.
REQ-022 Branch=1 SHALL take priority over pop and push in the same cycle.
REQ-023 FIFO full (count=2) SHALL suppress new requests, and empty SHALL give if_valid=0.
REQ-024 if_pc and if_instr SHALL show the head entry whenever if_valid=1.

Reset
REQ-025 rst_n=0 SHALL immediately force state=FETCH, PC=RESET_PC, FIFO empty, and if_valid=0, imem_req=0, imem_addr=0, if_pc=0, if_instr=0.
REQ-026 Reset during WAIT or DROP SHALL abandon the outstanding request, with no ack tracking afterwards.
REQ-027 The first request SHALL issue in the first cycle after rst_n rises.

Configuration
REQ-028 With macro FETCH_PERF_CNT_EN defined, SHALL add output redirect_cnt (32 bits) counting cycles with Branch=1, wrapping at 2^32, reset 0.
REQ-029 Without FETCH_PERF_CNT_EN, the redirect_cnt port and counter SHALL be absent and all other behaviour identical.

Structure
REQ-030 Package fetch_pkg SHALL hold the state enum, the FIFO entry struct {pc, instr}, the default reset-PC constant and the FIFO depth constant (2).
REQ-031 The FIFO SHALL be sub-module fetch_fifo (push, pop, flush, full, empty, head), with FSM and PC logic in fetch_unit.

Verification
REQ-032 Reset release with ack every cycle and id_ready=1 SHALL give imem_addr 0x0, 0x4, 0x8 and if_pc following in order.
REQ-033 id_ready=0 with ack held SHALL fill the FIFO with two entries, drop imem_req to 0, and resume fetching after one pop.
REQ-034 Branch=1 with BrPC=0x100 and nothing outstanding SHALL flush the FIFO, make the next imem_addr 0x100, and give if_valid=0 that next cycle.
REQ-035 Branch with BrPC=0x200 in WAIT, ack two cycles later, SHALL drop the ack data and make the next request 0x200.
REQ-036 Branch (BrPC=0x300) in the same cycle as imem_ack SHALL discard the data and make the next imem_addr 0x300.
REQ-037 rst_n pulsed low in DROP SHALL immediately give imem_req=0, then restart at RESET_PC, and with FETCH_PERF_CNT_EN SHALL reset redirect_cnt to 0.
